// File: rtl/ex_issue_scheduler.sv
// Reservation station with CDB wakeup and oldest-ready issue select for the single EX unit.
// Storage is a collapsing queue: entry 0 is the oldest and valid entries are contiguous from 0.
module ex_issue_scheduler #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             disp_valid,
    output logic                             disp_ready,
    input  logic [3:0]                       disp_unit,
    input  logic [4:0]                       disp_op,
    input  logic [31:0]                      disp_imme,
    input  logic [31:0]                      disp_pc,
    input  logic                             disp_src1_rdy,
    input  logic                             disp_src2_rdy,
    input  logic [TAG_W-1:0]                 disp_src1_tag,
    input  logic [TAG_W-1:0]                 disp_src2_tag,
    input  logic [31:0]                      disp_src1,
    input  logic [31:0]                      disp_src2,
    input  logic                             cdb_valid,
    input  logic [TAG_W-1:0]                 cdb_tag,
    input  logic [31:0]                      cdb_data,
    output logic                             iss_valid,
    input  logic                             iss_ready,
    output logic [3:0]                       iss_unit,
    output logic [4:0]                       iss_op,
    output logic [31:0]                      iss_imme,
    output logic [31:0]                      iss_pc,
    output logic [31:0]                      iss_src1,
    output logic [31:0]                      iss_src2,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]       unit;
        logic [4:0]       op;
        logic [31:0]      imme;
        logic [31:0]      pc;
        logic             s1_rdy;
        logic [TAG_W-1:0] s1_tag;
        logic [31:0]      s1;
        logic             s2_rdy;
        logic [TAG_W-1:0] s2_tag;
        logic [31:0]      s2;
    } ent_t;

    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    ent_t             woke  [DEPTH+1];
    ent_t             new_ent;
    ent_t             sel_ent;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] widx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             fire;
    logic             disp_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

    // Operand capture from the CDB; the extra top slot is the empty entry shifted in on issue.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            if (cdb_valid && !ent_q[i].s1_rdy && ent_q[i].s1_tag == cdb_tag) begin
                woke[i].s1_rdy = 1'b1;
                woke[i].s1     = cdb_data;
            end
            if (cdb_valid && !ent_q[i].s2_rdy && ent_q[i].s2_tag == cdb_tag) begin
                woke[i].s2_rdy = 1'b1;
                woke[i].s2     = cdb_data;
            end
        end
        woke[DEPTH] = '0;
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && CNT_W'(i) < count_q && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_ent    = ent_q[sel_idx];
        iss_valid  = sel_found && !flush;
        iss_unit   = iss_valid ? sel_ent.unit : 4'd0;
        iss_op     = iss_valid ? sel_ent.op   : 5'd0;
        iss_imme   = iss_valid ? sel_ent.imme : 32'd0;
        iss_pc     = iss_valid ? sel_ent.pc   : 32'd0;
        iss_src1   = iss_valid ? sel_ent.s1   : 32'd0;
        iss_src2   = iss_valid ? sel_ent.s2   : 32'd0;
        disp_ready = count_q < CNT_W'(DEPTH);
        count      = count_q;
        fire       = iss_valid && iss_ready;
        disp_acc   = disp_valid && disp_ready && !flush;
    end

    // Same-cycle CDB bypass into the dispatched entry.
    always_comb begin
        new_ent.unit   = disp_unit;
        new_ent.op     = disp_op;
        new_ent.imme   = disp_imme;
        new_ent.pc     = disp_pc;
        new_ent.s1_tag = disp_src1_tag;
        new_ent.s2_tag = disp_src2_tag;
        new_ent.s1_rdy = disp_src1_rdy;
        new_ent.s1     = disp_src1;
        new_ent.s2_rdy = disp_src2_rdy;
        new_ent.s2     = disp_src2;
        if (!disp_src1_rdy && cdb_valid && disp_src1_tag == cdb_tag) begin
            new_ent.s1_rdy = 1'b1;
            new_ent.s1     = cdb_data;
        end
        if (!disp_src2_rdy && cdb_valid && disp_src2_tag == cdb_tag) begin
            new_ent.s2_rdy = 1'b1;
            new_ent.s2     = cdb_data;
        end
    end

    always_comb begin
        widx = count_q - CNT_W'(fire);
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                ent_d[i] = '0;
            end else begin
                ent_d[i] = (fire && i >= int'(sel_idx)) ? woke[i+1] : woke[i];
                if (disp_acc && CNT_W'(i) == widx) ent_d[i] = new_ent;
            end
        end
        if (flush) count_d = '0;
        else       count_d = count_q + CNT_W'(disp_acc) - CNT_W'(fire);
    end

endmodule
